// File: rtl/cpu_pkg.sv
// Shared CPU types: default register/data widths, register-select and
// data-word typedefs, and the register-file write-port source encoding.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned REG_SEL_W_DEF = 5;

  typedef logic [REG_SEL_W_DEF-1:0] reg_select;
  typedef logic [DATA_W_DEF-1:0]    cpu_word;

  // Who owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_LOAD = 2'd1,
    WB_ALU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/load_writeback_queue_if.sv
// Bus bundle for the load write-back queue.
// slave : the queue's view (decoder/ALU/memory inputs, register-file and
//         hazard/status outputs).
// master: the surrounding pipeline's view.
interface load_writeback_queue_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_SEL_W = 5,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                 issueValid;
  logic [REG_SEL_W-1:0] issueRd;
  logic                 issueReady;
  logic                 memRespValid;
  logic [DATA_W-1:0]    memRespData;
  logic                 aluWE;
  logic [REG_SEL_W-1:0] aluRd;
  logic [DATA_W-1:0]    aluData;
  logic                 rfWE;
  logic [REG_SEL_W-1:0] rfRd;
  logic [DATA_W-1:0]    rfData;
  logic                 aluStall;
  logic [REG_SEL_W-1:0] checkRs1;
  logic [REG_SEL_W-1:0] checkRs2;
  logic [REG_SEL_W-1:0] checkRd;
  logic                 hazard;
  logic [CNT_W-1:0]     pendingCount;
  logic                 spuriousResp;

  modport slave (
    input  issueValid, issueRd, memRespValid, memRespData,
           aluWE, aluRd, aluData, checkRs1, checkRs2, checkRd,
    output issueReady, rfWE, rfRd, rfData, aluStall, hazard,
           pendingCount, spuriousResp
  );

  modport master (
    output issueValid, issueRd, memRespValid, memRespData,
           aluWE, aluRd, aluData, checkRs1, checkRs2, checkRd,
    input  issueReady, rfWE, rfRd, rfData, aluStall, hazard,
           pendingCount, spuriousResp
  );

endinterface

// File: rtl/rd_tag_fifo.sv
// Circular buffer of destination-register tags for in-order outstanding loads.
// Ports: clk/reset (async active-low); push/pushRd enqueue a tag; pop retires
// the head; headRd is the oldest tag; full/empty/count report occupancy;
// entryVec exposes {valid, tag} per slot for hazard comparison.
module rd_tag_fifo #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned REG_SEL_W = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [REG_SEL_W-1:0]             pushRd,
  input  logic                             pop,
  output logic [REG_SEL_W-1:0]             headRd,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic [DEPTH*(REG_SEL_W+1)-1:0]   entryVec
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = REG_SEL_W + 1;

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [DEPTH-1:0]     valid;
  logic [REG_SEL_W-1:0] entry [DEPTH];
  logic                 pushOk;
  logic                 popOk;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign pushOk = push && !full;
  assign popOk  = pop && !empty;
  assign headRd = entry[head];

  // Pointer, occupancy and slot storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      for (int i = 0; i < int'(DEPTH); i++) entry[i] <= '0;
    end else begin
      if (pushOk) begin
        entry[tail] <= pushRd;
        valid[tail] <= 1'b1;
        tail        <= nextPtr(tail);
      end
      if (popOk) begin
        valid[head] <= 1'b0;
        head        <= nextPtr(head);
      end
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_vec
    assign entryVec[g*ENT_W +: ENT_W] = {valid[g], entry[g]};
  end

endmodule

// File: rtl/load_writeback_queue.sv
// Tracks up to DEPTH in-order outstanding loads, arbitrates the single
// register-file write port (load responses beat ALU results), flags RAW/WAW
// hazards against pending loads, and latches responses that arrive with no
// load outstanding.
// Ports: clk; reset (async active-low); bus (slave modport) carries issue,
// memory response, ALU write-back, register-file write, hazard check and
// status (pendingCount, spuriousResp) signals.
module load_writeback_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned REG_SEL_W = REG_SEL_W_DEF,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  load_writeback_queue_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = REG_SEL_W + 1;

  logic                     fifoFull;
  logic                     fifoEmpty;
  logic                     issueAccept;
  logic                     respValid;
  logic [REG_SEL_W-1:0]     headRd;
  logic [CNT_W-1:0]         count;
  logic [DEPTH*ENT_W-1:0]   entryVec;
  logic                     spuriousQ;
  logic                     anyHit;
  wb_src_e                  wbSrc;

  // Readiness depends on current occupancy only; a same-cycle retire does
  // not free a slot for a same-cycle issue.
  assign issueAccept = bus.issueValid && !fifoFull;
  // A response with nothing outstanding never reaches the register file,
  // even if a load is being issued in the same cycle.
  assign respValid   = bus.memRespValid && !fifoEmpty;

  rd_tag_fifo #(
    .DEPTH     (DEPTH),
    .REG_SEL_W (REG_SEL_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (issueAccept),
    .pushRd   (bus.issueRd),
    .pop      (respValid),
    .headRd   (headRd),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (count),
    .entryVec (entryVec)
  );

  // Write-port arbitration: load write-back wins, ALU is stalled.
  always_comb begin
    wbSrc        = WB_NONE;
    bus.rfWE     = 1'b0;
    bus.rfRd     = bus.aluRd;
    bus.rfData   = bus.aluData;
    bus.aluStall = 1'b0;
    if (respValid) begin
      wbSrc        = WB_LOAD;
      bus.rfRd     = headRd;
      bus.rfData   = bus.memRespData;
      bus.aluStall = bus.aluWE;
    end else if (bus.aluWE) begin
      wbSrc = WB_ALU;
    end
    bus.rfWE = (wbSrc != WB_NONE);
  end

  // Hazard: any valid pending tag matching a decode operand, including a
  // head that is retiring this cycle.
  always_comb begin
    anyHit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entryVec[i*ENT_W + REG_SEL_W] &&
          ((entryVec[i*ENT_W +: REG_SEL_W] == bus.checkRs1) ||
           (entryVec[i*ENT_W +: REG_SEL_W] == bus.checkRs2) ||
           (entryVec[i*ENT_W +: REG_SEL_W] == bus.checkRd))) begin
        anyHit = 1'b1;
      end
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spuriousQ <= 1'b0;
    end else if (bus.memRespValid && fifoEmpty) begin
      spuriousQ <= 1'b1;
    end
  end

  assign bus.issueReady   = !fifoFull;
  assign bus.hazard       = anyHit;
  assign bus.pendingCount = count;
  assign bus.spuriousResp = spuriousQ;

endmodule

// File: tb/tb_load_writeback_queue.sv
module tb_load_writeback_queue;
  import cpu_pkg::*;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_SEL_W = 5;
  localparam int unsigned DEPTH     = 4;
  localparam int          N         = 31;  // operand value never issued

  typedef struct {
    logic      iv;
    reg_select ird;
    logic      rv;
    cpu_word   rdata;
    logic      aw;
    reg_select ard;
    cpu_word   adata;
    reg_select rs1;
    reg_select rs2;
    reg_select crd;
    logic      eWe;
    reg_select eRd;
    cpu_word   eData;
    logic      eStall;
    logic      eHaz;
    int        eCnt;
    logic      eReady;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_writeback_queue_if #(.DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W), .DEPTH(DEPTH)) bus ();

  load_writeback_queue #(.DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int        nChecks = 0;
  int        nFail   = 0;
  reg_select sbQ[$];
  logic      sbSpur  = 1'b0;
  vec_t      tbl[$];
  vec_t      seq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input int ird, input logic rv, input logic [31:0] rdata,
                              input logic aw, input int ard, input logic [31:0] adata,
                              input int rs1, input int rs2, input int crd,
                              input logic eWe, input int eRd, input logic [31:0] eData,
                              input logic eStall, input logic eHaz, input int eCnt, input logic eReady);
    vec_t v;
    v.iv = iv; v.ird = REG_SEL_W'(ird); v.rv = rv; v.rdata = rdata;
    v.aw = aw; v.ard = REG_SEL_W'(ard); v.adata = adata;
    v.rs1 = REG_SEL_W'(rs1); v.rs2 = REG_SEL_W'(rs2); v.crd = REG_SEL_W'(crd);
    v.eWe = eWe; v.eRd = REG_SEL_W'(eRd); v.eData = eData;
    v.eStall = eStall; v.eHaz = eHaz; v.eCnt = eCnt; v.eReady = eReady;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.issueValid   = v.iv;
    bus.issueRd      = v.ird;
    bus.memRespValid = v.rv;
    bus.memRespData  = v.rdata;
    bus.aluWE        = v.aw;
    bus.aluRd        = v.ard;
    bus.aluData      = v.adata;
    bus.checkRs1     = v.rs1;
    bus.checkRs2     = v.rs2;
    bus.checkRd      = v.crd;
  endtask

  // Drive one cycle just after a falling edge, check mid-low-phase, clock it.
  task automatic runVec(input vec_t v, input string tag);
    int        sizeBefore;
    reg_select expRd;
    sizeBefore = sbQ.size();
    drive(v);
    #2;
    chk({tag, ".rfWE"},       32'(bus.rfWE),         32'(v.eWe));
    chk({tag, ".rfRd"},       32'(bus.rfRd),         32'(v.eRd));
    chk({tag, ".rfData"},     32'(bus.rfData),       32'(v.eData));
    chk({tag, ".aluStall"},   32'(bus.aluStall),     32'(v.eStall));
    chk({tag, ".hazard"},     32'(bus.hazard),       32'(v.eHaz));
    chk({tag, ".pending"},    32'(bus.pendingCount), 32'(v.eCnt));
    chk({tag, ".issueReady"}, 32'(bus.issueReady),   32'(v.eReady));
    chk({tag, ".sbCount"},    32'(bus.pendingCount), 32'(sizeBefore));
    chk({tag, ".sbSpurious"}, 32'(bus.spuriousResp), 32'(sbSpur));
    if (v.rv && sizeBefore > 0) begin
      expRd = sbQ.pop_front();
      chk({tag, ".sbRd"},   32'(bus.rfRd),   32'(expRd));
      chk({tag, ".sbData"}, 32'(bus.rfData), 32'(v.rdata));
    end else if (v.rv) begin
      sbSpur = 1'b1;
    end
    if (v.iv && sizeBefore < int'(DEPTH)) sbQ.push_back(v.ird);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drive(mk(0,0,0,0,0,0,0,N,N,N,0,0,0,0,0,0,1));
    #1;
    chk("reset.issueReady", 32'(bus.issueReady),   32'd1);
    chk("reset.rfWE",       32'(bus.rfWE),         32'd0);
    chk("reset.hazard",     32'(bus.hazard),       32'd0);
    chk("reset.pending",    32'(bus.pendingCount), 32'd0);
    chk("reset.spurious",   32'(bus.spuriousResp), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    //            iv ird rv rdata        aw ard adata  rs1 rs2 crd | we rd data         st hz cnt rdy
    tbl.push_back(mk(1, 5, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 0, 0,   N, N, N,  1, 5, 32'hDEADBEEF, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(1, 2, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 1, 1));
    tbl.push_back(mk(1, 3, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 2, 1));
    tbl.push_back(mk(1, 4, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 3, 1));
    tbl.push_back(mk(1, 9, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 4, 0));
    tbl.push_back(mk(1, 9, 1, 32'hA,        0, 0, 0,   N, N, N,  1, 1, 32'hA,        0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 1, 32'hB,        0, 0, 0,   N, N, N,  1, 2, 32'hB,        0, 0, 3, 1));
    tbl.push_back(mk(0, 0, 1, 32'hC,        0, 0, 0,   N, N, N,  1, 3, 32'hC,        0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 1, 32'hD,        0, 0, 0,   N, N, N,  1, 4, 32'hD,        0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(1, 10, 0, 0,           0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(1, 11, 1, 32'h10,      0, 0, 0,   N, N, N,  1, 10, 32'h10,      0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h11,       0, 0, 0,   N, N, N,  1, 11, 32'h11,      0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(1, 2, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'hAB,       1, 7, 32'h55, N, N, N, 1, 2, 32'hAB,     1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,            1, 7, 32'h55, N, N, N, 1, 7, 32'h55,     0, 0, 0, 1));
    tbl.push_back(mk(1, 6, 0, 0,            0, 0, 0,   N, 6, N,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,   N, 6, N,  0, 0, 0,            0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h66,       0, 0, 0,   N, 6, N,  1, 6, 32'h66,       0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,   N, 6, N,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(1, 6, 0, 0,            0, 0, 0,   N, N, 6,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,   N, N, 6,  0, 0, 0,            0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h67,       0, 0, 0,   N, N, 6,  1, 6, 32'h67,       0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,   N, N, 6,  0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(1, 12, 0, 0,           0, 0, 0,   12, N, N, 0, 0, 0,            0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,   12, N, N, 0, 0, 0,            0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h12,       0, 0, 0,   12, N, N, 1, 12, 32'h12,      0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,   12, N, N, 0, 0, 0,            0, 0, 0, 1));

    foreach (tbl[i]) runVec(tbl[i], $sformatf("row%0d", i));

    // Spurious response with empty queue, sticky, then loads pending for reset.
    seq.push_back(mk(0, 0, 1, 32'hBAD,      1, 3, 32'h33, N, N, N, 1, 3, 32'h33,     0, 0, 0, 1));
    seq.push_back(mk(0, 0, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 0, 1));
    seq.push_back(mk(1, 8, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 0, 1));
    seq.push_back(mk(1, 9, 0, 0,            0, 0, 0,   N, N, N,  0, 0, 0,            0, 0, 1, 1));
    seq.push_back(mk(0, 0, 0, 0,            0, 0, 0,   8, N, N,  0, 0, 0,            0, 1, 2, 1));
    foreach (seq[i]) runVec(seq[i], $sformatf("seq%0d", i));
    chk("spurious.held", 32'(bus.spuriousResp), 32'd1);

    // Asynchronous reset in the middle of the low phase, with no clock edge.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 8, N, N, 0, 0, 0, 0, 0, 0, 1));
    #2;
    reset = 1'b0;
    #1;
    chk("midReset.pending",    32'(bus.pendingCount), 32'd0);
    chk("midReset.spurious",   32'(bus.spuriousResp), 32'd0);
    chk("midReset.hazard",     32'(bus.hazard),       32'd0);
    chk("midReset.issueReady", 32'(bus.issueReady),   32'd1);
    sbQ.delete();
    sbSpur = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    runVec(mk(0, 0, 1, 32'h99, 0, 0, 0, N, N, N, 0, 0, 0, 0, 0, 0, 1), "postReset.resp");
    runVec(mk(0, 0, 0, 0,      0, 0, 0, N, N, N, 0, 0, 0, 0, 0, 0, 1), "postReset.idle");
    chk("postReset.spurious", 32'(bus.spuriousResp), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
